// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table evaluation engine.
package tt_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } tt_state_e;

  function automatic int tt_depth(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_table_mem.sv
// Register-array lookup table: async-cleared, synchronous write, combinational read.
module tt_table_mem
  import tt_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [N_IN-1:0]  waddr,
  input  logic [N_OUT-1:0] wdata,
  input  logic [N_IN-1:0]  raddr,
  output logic [N_OUT-1:0] rdata
);

  localparam int DEPTH = tt_depth(N_IN);

  logic [N_OUT-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tt_eval_engine.sv
// Programmable truth-table evaluator: burst-loaded table, valid/ready evaluation stream.
//   state   | meaning
//   EMPTY   | no load started since reset, evaluation blocked
//   LOADING | accepting cfg words into table[addr], evaluation blocked
//   READY   | table complete, evaluating input vectors
module tt_eval_engine
  import tt_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [N_OUT-1:0] cfg_data,
  output logic             cfg_err,
  output logic             loaded,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data
);

  localparam int DEPTH = tt_depth(N_IN);
  localparam logic [N_IN-1:0] LAST_ADDR = N_IN'(DEPTH - 1);

  tt_state_e        state;
  logic [N_IN-1:0]  addr;
  logic             we;
  logic             accept;
  logic [N_OUT-1:0] rdata;

  // cfg_start blocks acceptance so a reload never races an evaluation.
  assign in_ready = (state == READY) && !cfg_start && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign we       = (state == LOADING) && cfg_valid && !cfg_start;

  tt_table_mem #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (addr),
    .wdata (cfg_data),
    .raddr (in_data),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      addr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      if (cfg_start)
        cfg_err <= 1'b0;
      else if (cfg_valid && state != LOADING)
        cfg_err <= 1'b1;

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= rdata;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        EMPTY: begin
          if (cfg_start) begin
            state <= LOADING;
            addr  <= '0;
          end
        end
        LOADING: begin
          if (cfg_start) begin
            addr <= '0;
          end else if (cfg_valid) begin
            if (addr == LAST_ADDR) begin
              state  <= READY;
              loaded <= 1'b1;
              addr   <= '0;
            end else begin
              addr <= addr + N_IN'(1);
            end
          end
        end
        READY: begin
          if (cfg_start) begin
            state <= LOADING;
            addr  <= '0;
          end
        end
        default: begin
          state <= EMPTY;
          addr  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_eval_engine.sv
// Directed bench for tt_eval_engine with hand-computed table contents.
module tb_tt_eval_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start, cfg_valid;
  logic [1:0] cfg_data;
  logic       cfg_err, loaded;
  logic       in_valid, in_ready;
  logic [2:0] in_data;
  logic       out_valid, out_ready;
  logic [1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [1:0] tbl_a   [8] = '{2'b11, 2'b00, 2'b11, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00};
  logic [1:0] tbl_01  [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [1:0] tbl_00  [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

  always #5 clk = ~clk;

  tt_eval_engine #(.N_IN(3), .N_OUT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .loaded    (loaded),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full load; optionally checks a pending result stays frozen on the output.
  task automatic do_load(input logic [1:0] w [8], input bit start_with_valid,
                         input bit chk_hold, input logic [1:0] hold_val,
                         input logic pre_loaded);
    cfg_start = 1'b1;
    cfg_valid = start_with_valid;
    cfg_data  = 2'b10;
    tick();
    cfg_start = 1'b0;
    check("err_after_start", cfg_err, 0);
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = w[i];
      if (i == 7) check("loaded_before_last", loaded, pre_loaded);
      tick();
      if (chk_hold) begin
        check("hold_data", out_data, hold_val);
        check("hold_valid", out_valid, 1);
      end
    end
    cfg_valid = 1'b0;
    check("loaded_after_load", loaded, 1);
    check("err_after_load", cfg_err, 0);
  endtask

  task automatic stream(input logic [1:0] e [8]);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 3'(i);
      #1;
      check("stream_ready", in_ready, 1);
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, e[i]);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_loaded", loaded, 0);
    check("rst_in_ready", in_ready, 0);

    in_valid = 1'b1;
    in_data  = 3'd0;
    repeat (20) begin
      tick();
      check("empty_in_ready", in_ready, 0);
      check("empty_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    do_load(tbl_a, 1'b0, 1'b0, 2'b00, 1'b0);
    check("ready_after_load", in_ready, 1);
    stream(tbl_a);
    check("stream_cfg_err", cfg_err, 0);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 3'd3;
    tick();
    check("bp_first_valid", out_valid, 1);
    check("bp_first_data", out_data, 2'b10);
    in_data = 3'd6;
    repeat (5) begin
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_hold_data", out_data, 2'b10);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_next_data", out_data, 2'b10);
    check("bp_next_valid", out_valid, 1);
    in_data = 3'd5;
    tick();
    check("bp_after_data", out_data, 2'b00);
    in_valid = 1'b0;
    tick();
    check("bp_drain", out_valid, 0);

    // stray cfg word while READY
    cfg_valid = 1'b1;
    cfg_data  = 2'b00;
    tick();
    cfg_valid = 1'b0;
    check("err_set", cfg_err, 1);
    in_valid = 1'b1;
    in_data  = 3'd2;
    tick();
    check("err_table_kept", out_data, 2'b11);
    in_valid = 1'b0;
    tick();
    check("err_sticky", cfg_err, 1);

    // reload with a result pending
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 3'd2;
    tick();
    in_valid = 1'b0;
    check("pend_data", out_data, 2'b11);
    do_load(tbl_01, 1'b1, 1'b1, 2'b11, 1'b1);
    check("pend_in_ready", in_ready, 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 3'd0;
    #1;
    check("reload_ready", in_ready, 1);
    tick();
    check("reload_d0", out_data, 2'b01);
    in_data = 3'd2;
    tick();
    check("reload_d2", out_data, 2'b01);
    in_valid = 1'b0;
    tick();

    // reset in the middle of a load with a result pending
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 3'd1;
    tick();
    in_valid  = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 2'b11;
    repeat (4) tick();
    cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_data", out_data, 0);
    check("mrst_loaded", loaded, 0);
    check("mrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 3'd0;
    tick();
    check("mrst_empty", in_ready, 0);
    check("mrst_no_out", out_valid, 0);
    in_valid = 1'b0;
    do_load(tbl_00, 1'b0, 1'b0, 2'b00, 1'b0);
    stream(tbl_00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_eval_engine.md
# tt_eval_engine

Programmable truth-table evaluator: holds a 2^N_IN-entry × N_OUT-bit lookup table in registers, loaded in bursts over a config port, and evaluates input vectors through a valid/ready stream with a registered result. It replaces hard-coded case-statement logic blocks in synthesized netlists, so one instance can realise any N_IN-input / N_OUT-output function and be reprogrammed at run time.

## Interface
- N_IN, default 3: input vector width; table depth DEPTH = 2^N_IN.
- N_OUT, default 2: output word width.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  begin table load; address counter resets to 0.
- cfg_valid  in  1  cfg_data word present.
- cfg_data  in  N_OUT  table word for current load address.
- cfg_err  out  1  sticky: cfg_valid seen outside LOADING; cleared by accepted cfg_start.
- loaded  out  1  table fully written at least once since reset.
- in_valid  in  1  input vector present.
- in_ready  out  1  engine accepts in_data this cycle.
- in_data  in  N_IN  input vector; bit 0 = first input.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_data  out  N_OUT  table[in_data]; bit N_OUT-1 = first output.

## Operation
- States: EMPTY (reset), LOADING, READY.
- EMPTY: in_ready=0. cfg_start -> LOADING.
- LOADING: each cycle with cfg_valid=1 writes cfg_data to table[addr], addr++. Write at addr=DEPTH-1 -> READY, loaded=1. cfg_start in LOADING restarts at addr 0 (partial load discarded logically; written words remain).
- READY: in_ready = !cfg_start && (!out_valid || out_ready). Accept -> out_data <= table[in_data], out_valid <= 1. cfg_start -> LOADING; evaluation blocked until load completes.
- Pending output (out_valid=1) is held stable, unaffected by table writes or cfg_start, until out_ready.
- cfg_valid in EMPTY/READY: ignored, cfg_err <= 1. cfg_start and cfg_valid in same cycle: start wins, data ignored, no error.
- Table contents reset to all zeros; loaded never clears except by rst.

## Timing
- Reset values: state=EMPTY, addr=0, table=0, out_valid=0, out_data=0, cfg_err=0, loaded=0, in_ready=0.
- Latency: in accept at edge k -> out_valid=1, out_data valid after edge k; throughput 1/cycle with out_ready held high.
- Backpressure: out_valid && !out_ready -> in_ready=0 combinationally; no data lost or duplicated.
- Load: DEPTH accepted cfg words; READY first visible the cycle after the last write; in_ready can assert that cycle.
- in_ready depends combinationally on cfg_start and out_ready only; no combinational path from in_valid to in_ready.
- rst asserted mid-load or mid-stream: all state to reset values immediately; pending result discarded.

## Structure
- Package tt_pkg: state enum tt_state_e {EMPTY, LOADING, READY}; function tt_depth(n) = 1<<n.
- Sub-module tt_table_mem: DEPTH × N_OUT register array, async-reset to 0, synchronous write (we, waddr, wdata), combinational read (raddr -> rdata). Top holds FSM, address counter, output register, flags.

## Test plan
- Reset then load 8 words 11,00,11,10,11,00,10,00 (N_IN=3, N_OUT=2); stream in_data 0..7 with out_ready=1 -> out_data 11,00,11,10,11,00,10,00 one cycle later each, back-to-back, loaded=1, cfg_err=0.
- Before any load, in_valid=1 -> in_ready=0 for 20 cycles, out_valid stays 0.
- Hold out_ready=0 after one result (in_data=3 -> 10) for 5 cycles -> out_data stays 10, in_ready=0; release -> next vector accepted same cycle.
- In READY, assert cfg_start with a result pending, reload with all 01 -> pending result unchanged on output; after reload in_data=0 -> 01.
- cfg_valid=1 in READY -> cfg_err=1, table unchanged (in_data=2 still 11); next cfg_start clears cfg_err.
- Assert rst during LOADING at addr=4 -> state EMPTY, loaded=0, table reads 00 after fresh full load of zeros, out_valid=0.
